// File: rtl/mips_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// mips_axi_rd_arbiter
//
// Serialises the MIPS core's instruction-fetch and data-load read requests onto
// a single AXI AR/R channel pair, with at most one transaction outstanding.
// The AR side (axi_araddr, axi_arvalid) is driven from registers. The R
// response is routed back to whichever requester owns the current transaction.
// Grant, wait and read-error counters feed the performance-counter bank.
//
// Configuration macro:
//   MIPS_RD_ARB_RR_EN  - defined: round-robin on ties (the requester that was
//                        not granted last wins).
//                        undefined: fixed priority, data beats inst.
//
// Ports:
//   mips_cpu_clk, mips_cpu_reset_n        clock, async active-low reset
//   inst_req_valid/addr, inst_req_ack     fetch request, AR-handshake pulse
//   inst_rdata/rvalid, inst_rack          fetch read data and its handshake
//   data_req_* / data_r*                  same set for the load requester
//   axi_ar* / axi_r*                      AXI read address and read data channels
//   cnt_inst_grant, cnt_data_grant        grants issued per requester
//   cnt_wait                              cycles stalled on arready or rvalid
//   cnt_rd_err                            responses with a nonzero rresp
// -----------------------------------------------------------------------------
module mips_axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              mips_cpu_clk,
    input  logic              mips_cpu_reset_n,
    input  logic              inst_req_valid,
    input  logic [ADDR_W-1:0] inst_req_addr,
    output logic              inst_req_ack,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_rvalid,
    input  logic              inst_rack,
    input  logic              data_req_valid,
    input  logic [ADDR_W-1:0] data_req_addr,
    output logic              data_req_ack,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_rvalid,
    input  logic              data_rack,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rvalid,
    output logic              axi_rready,
    output logic [31:0]       cnt_inst_grant,
    output logic [31:0]       cnt_data_grant,
    output logic [31:0]       cnt_wait,
    output logic [31:0]       cnt_rd_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_e;

    state_e state_r;
    logic   own_r;              // 0 = inst owns the transaction, 1 = data
`ifdef MIPS_RD_ARB_RR_EN
    logic   last_grant_r;       // 0 = inst was granted last, 1 = data
`endif

    logic   win_s;              // arbitration winner, same encoding as own_r
    logic   in_addr_s;
    logic   in_data_s;
    logic   owner_rack_s;
    logic   ar_hs_s;
    logic   r_hs_s;
    logic   wait_s;

    // Arbitration: pick the requester that wins if granted this cycle.
    always_comb begin
`ifdef MIPS_RD_ARB_RR_EN
        if (inst_req_valid && data_req_valid) begin
            win_s = ~last_grant_r;
        end else begin
            win_s = data_req_valid;
        end
`else
        win_s = data_req_valid;
`endif
    end

    // Handshake decode and combinational routing of acks and R data to the owner.
    always_comb begin
        in_addr_s    = (state_r == ST_ADDR);
        in_data_s    = (state_r == ST_DATA);
        owner_rack_s = own_r ? data_rack : inst_rack;
        ar_hs_s      = in_addr_s & axi_arready;
        r_hs_s       = in_data_s & axi_rvalid & owner_rack_s;
        wait_s       = (in_addr_s & ~axi_arready) | (in_data_s & ~axi_rvalid);

        inst_req_ack = ar_hs_s & ~own_r;
        data_req_ack = ar_hs_s & own_r;
        axi_rready   = in_data_s & owner_rack_s;
        inst_rvalid  = in_data_s & ~own_r & axi_rvalid;
        data_rvalid  = in_data_s & own_r & axi_rvalid;

        if (in_data_s && !own_r) begin
            inst_rdata = axi_rdata;
        end else begin
            inst_rdata = {DATA_W{1'b0}};
        end

        if (in_data_s && own_r) begin
            data_rdata = axi_rdata;
        end else begin
            data_rdata = {DATA_W{1'b0}};
        end
    end

    // Transaction FSM, registered AR outputs and performance counters.
    always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
        if (!mips_cpu_reset_n) begin
            state_r        <= ST_IDLE;
            own_r          <= 1'b0;
            axi_arvalid    <= 1'b0;
            axi_araddr     <= {ADDR_W{1'b0}};
            cnt_inst_grant <= 32'd0;
            cnt_data_grant <= 32'd0;
            cnt_wait       <= 32'd0;
            cnt_rd_err     <= 32'd0;
`ifdef MIPS_RD_ARB_RR_EN
            last_grant_r   <= 1'b1;
`endif
        end else begin
            if (wait_s) begin
                cnt_wait <= cnt_wait + 32'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (inst_req_valid || data_req_valid) begin
                        own_r       <= win_s;
                        axi_araddr  <= win_s ? data_req_addr : inst_req_addr;
                        axi_arvalid <= 1'b1;
                        state_r     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        if (own_r) begin
                            cnt_data_grant <= cnt_data_grant + 32'd1;
                        end else begin
                            cnt_inst_grant <= cnt_inst_grant + 32'd1;
                        end
`ifdef MIPS_RD_ARB_RR_EN
                        last_grant_r <= own_r;
`endif
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // An error response is still delivered; it is only counted.
                    if (r_hs_s) begin
                        if (axi_rresp != 2'b00) begin
                            cnt_rd_err <= cnt_rd_err + 32'd1;
                        end
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    axi_arvalid <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mips_axi_rd_arbiter. A transaction-level reference
// model tracks bus ownership and pushes each expected grant into a queue. A
// monitor on the falling edge pops the queue on every DUT ack and also checks
// the routing and counter outputs against the model.
// -----------------------------------------------------------------------------
module tb_mips_axi_rd_arbiter;

    logic        mips_cpu_clk = 1'b0;
    logic        mips_cpu_reset_n;
    logic        inst_req_valid, data_req_valid;
    logic [31:0] inst_req_addr, data_req_addr;
    logic        inst_req_ack, data_req_ack;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_rvalid, data_rvalid;
    logic        inst_rack, data_rack;
    logic [31:0] axi_araddr;
    logic        axi_arvalid, axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid, axi_rready;
    logic [31:0] cnt_inst_grant, cnt_data_grant, cnt_wait, cnt_rd_err;

    always #5 mips_cpu_clk = ~mips_cpu_clk;

    mips_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .mips_cpu_clk(mips_cpu_clk), .mips_cpu_reset_n(mips_cpu_reset_n),
        .inst_req_valid(inst_req_valid), .inst_req_addr(inst_req_addr),
        .inst_req_ack(inst_req_ack), .inst_rdata(inst_rdata),
        .inst_rvalid(inst_rvalid), .inst_rack(inst_rack),
        .data_req_valid(data_req_valid), .data_req_addr(data_req_addr),
        .data_req_ack(data_req_ack), .data_rdata(data_rdata),
        .data_rvalid(data_rvalid), .data_rack(data_rack),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .cnt_inst_grant(cnt_inst_grant), .cnt_data_grant(cnt_data_grant),
        .cnt_wait(cnt_wait), .cnt_rd_err(cnt_rd_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Bus phases: 0 = free, 1 = address offered, 2 = awaiting read data.
    typedef struct packed { logic own; logic [31:0] addr; } txn_t;
    txn_t        exp_q[$];
    int          m_ph;
    logic        m_own, m_last;
    logic [31:0] m_addr, m_ig, m_dg, m_wait, m_err;
    logic        ack_i, ack_d;

    always @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
        if (!mips_cpu_reset_n) begin
            m_ph = 0; m_own = 1'b0; m_last = 1'b1; m_addr = 32'd0;
            m_ig = 32'd0; m_dg = 32'd0; m_wait = 32'd0; m_err = 32'd0;
            ack_i = 1'b0; ack_d = 1'b0;
            exp_q.delete();
        end else begin
            ack_i = 1'b0; ack_d = 1'b0;
            if (m_ph == 0) begin
                if (inst_req_valid || data_req_valid) begin
                    if (inst_req_valid && data_req_valid) begin
`ifdef MIPS_RD_ARB_RR_EN
                        m_own = ~m_last;
`else
                        m_own = 1'b1;
`endif
                    end else begin
                        m_own = data_req_valid;
                    end
                    m_addr = m_own ? data_req_addr : inst_req_addr;
                    exp_q.push_back('{own: m_own, addr: m_addr});
                    m_ph = 1;
                end
            end else if (m_ph == 1) begin
                if (axi_arready) begin
                    if (m_own) begin m_dg = m_dg + 32'd1; ack_d = 1'b1; end
                    else       begin m_ig = m_ig + 32'd1; ack_i = 1'b1; end
                    m_last = m_own;
                    m_ph = 2;
                end else begin
                    m_wait = m_wait + 32'd1;
                end
            end else begin
                if (!axi_rvalid) begin
                    m_wait = m_wait + 32'd1;
                end else if (m_own ? data_rack : inst_rack) begin
                    if (axi_rresp != 2'b00) m_err = m_err + 32'd1;
                    m_ph = 0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge mips_cpu_clk) begin
        if (mips_cpu_reset_n) begin
            logic own_rack;
            txn_t t;
            own_rack = m_own ? data_rack : inst_rack;
            chk("arvalid", 32'(axi_arvalid), 32'(m_ph == 1));
            if (m_ph == 1) chk("araddr", axi_araddr, m_addr);
            chk("inst_req_ack", 32'(inst_req_ack), 32'(m_ph == 1 && axi_arready && !m_own));
            chk("data_req_ack", 32'(data_req_ack), 32'(m_ph == 1 && axi_arready && m_own));
            chk("rready", 32'(axi_rready), 32'(m_ph == 2 && own_rack));
            chk("inst_rvalid", 32'(inst_rvalid), 32'(m_ph == 2 && !m_own && axi_rvalid));
            chk("data_rvalid", 32'(data_rvalid), 32'(m_ph == 2 && m_own && axi_rvalid));
            if (m_ph == 2) begin
                chk("inst_rdata", inst_rdata, m_own ? 32'd0 : axi_rdata);
                chk("data_rdata", data_rdata, m_own ? axi_rdata : 32'd0);
            end
            chk("cnt_inst_grant", cnt_inst_grant, m_ig);
            chk("cnt_data_grant", cnt_data_grant, m_dg);
            chk("cnt_wait", cnt_wait, m_wait);
            chk("cnt_rd_err", cnt_rd_err, m_err);
            if (inst_req_ack || data_req_ack) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL grant_unexpected: got ack with empty queue at %0t", $time);
                end else begin
                    t = exp_q.pop_front();
                    chk("grant_owner", 32'(data_req_ack), 32'(t.own));
                    chk("grant_addr", axi_araddr, t.addr);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Advance one cycle; requesters drop valid right after their ack.
    task automatic step();
        @(posedge mips_cpu_clk);
        #2;
        if (ack_i) inst_req_valid = 1'b0;
        if (ack_d) data_req_valid = 1'b0;
    endtask

    task automatic slave_ready();
        axi_arready = 1'b1; axi_rvalid = 1'b1; inst_rack = 1'b1; data_rack = 1'b1;
        axi_rresp = 2'b00;
    endtask

    task automatic quiet();
        inst_req_valid = 1'b0; data_req_valid = 1'b0;
        slave_ready();
        repeat (4) step();
    endtask

    task automatic rnd_drive();
        axi_arready = ($urandom_range(0, 3) != 0);
        axi_rvalid  = ($urandom_range(0, 3) != 0);
        inst_rack   = ($urandom_range(0, 3) != 0);
        data_rack   = ($urandom_range(0, 3) != 0);
        axi_rdata   = $urandom;
        axi_rresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        if (!inst_req_valid && $urandom_range(0, 2) == 0) begin
            inst_req_valid = 1'b1;
            inst_req_addr  = $urandom & 32'hFFFF_FFFC;
        end
        if (!data_req_valid && $urandom_range(0, 2) == 0) begin
            data_req_valid = 1'b1;
            data_req_addr  = $urandom & 32'hFFFF_FFFC;
        end
    endtask

    initial begin
        logic [31:0] base, exp_addr;
        int n;
        inst_req_valid = 1'b0; data_req_valid = 1'b0;
        inst_req_addr = 32'd0; data_req_addr = 32'd0;
        inst_rack = 1'b0; data_rack = 1'b0;
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = 32'd0; axi_rresp = 2'b00;
        mips_cpu_reset_n = 1'b0;
        #7;
        chk("rst_araddr", axi_araddr, 32'd0);
        chk("rst_arvalid", 32'(axi_arvalid), 32'd0);
        chk("rst_acks", 32'({inst_req_ack, data_req_ack}), 32'd0);
        chk("rst_rvalids", 32'({inst_rvalid, data_rvalid, axi_rready}), 32'd0);
        chk("rst_counters", cnt_inst_grant | cnt_data_grant | cnt_wait | cnt_rd_err, 32'd0);
        #5 mips_cpu_reset_n = 1'b1;
        step();

        // Four consecutive ties.
        slave_ready();
        inst_req_addr = 32'h0000_0104; data_req_addr = 32'h0000_2000;
        inst_req_valid = 1'b1; data_req_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            step();
`ifdef MIPS_RD_ARB_RR_EN
            exp_addr = (g % 2 == 0) ? 32'h0000_0104 : 32'h0000_2000;
`else
            exp_addr = 32'h0000_2000;
`endif
            chk("tie_order", axi_araddr, exp_addr);
            step();
            inst_req_valid = 1'b1; data_req_valid = 1'b1;
            step();
        end
`ifdef MIPS_RD_ARB_RR_EN
        chk("tie_data_grants", cnt_data_grant, 32'd2);
`else
        chk("tie_data_grants", cnt_data_grant, 32'd4);
`endif
        quiet();

        // Single fetch with latency checks.
        base = cnt_inst_grant;
        axi_rdata = 32'h2402_0005;
        inst_req_addr = 32'h0000_0100; inst_req_valid = 1'b1;
        step();
        chk("fetch_arvalid", 32'({axi_arvalid, inst_req_ack}), 32'd3);
        chk("fetch_araddr", axi_araddr, 32'h0000_0100);
        step();
        chk("fetch_rvalid", 32'(inst_rvalid), 32'd1);
        chk("fetch_rdata", inst_rdata, 32'h2402_0005);
        step();
        chk("fetch_grant", cnt_inst_grant - base, 32'd1);
        quiet();

        // Backpressure: arready low 3 cycles, then rvalid low 2 cycles.
        base = cnt_wait;
        axi_arready = 1'b0; axi_rvalid = 1'b0;
        inst_req_addr = 32'h0000_0200; inst_req_valid = 1'b1;
        repeat (4) step();
        axi_arready = 1'b1;
        repeat (3) step();
        axi_rvalid = 1'b1;
        step();
        chk("bp_wait", cnt_wait - base, 32'd5);
        quiet();

        // Error response on a data read.
        base = cnt_rd_err;
        axi_rresp = 2'b10; axi_rdata = 32'hDEAD_BEEF;
        data_req_addr = 32'h0000_3000; data_req_valid = 1'b1;
        step();
        step();
        chk("err_rvalid", 32'(data_rvalid), 32'd1);
        chk("err_rdata", data_rdata, 32'hDEAD_BEEF);
        step();
        chk("err_cnt", cnt_rd_err - base, 32'd1);
        quiet();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rnd_drive();
            step();
        end

        // Async reset while waiting for read data.
        n = 0;
        while (m_ph != 2 && n < 200) begin
            rnd_drive();
            step();
            n++;
        end
        chk("reset_reach_data_timeout", 32'(m_ph == 2), 32'd1);
        axi_rvalid = 1'b0;
        #1 mips_cpu_reset_n = 1'b0;
        #1;
        chk("async_rst_arvalid", 32'({axi_arvalid, axi_rready}), 32'd0);
        chk("async_rst_counters", cnt_inst_grant | cnt_data_grant | cnt_wait | cnt_rd_err, 32'd0);
        inst_req_valid = 1'b0; data_req_valid = 1'b0;
        #4 mips_cpu_reset_n = 1'b1;
        slave_ready();
        axi_rdata = 32'h8C43_0010;
        inst_req_addr = 32'h0000_0400; inst_req_valid = 1'b1;
        step();
        step();
        chk("post_rst_rdata", inst_rdata, 32'h8C43_0010);
        step();
        chk("post_rst_grant", cnt_inst_grant, 32'd1);
        quiet();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_axi_rd_arbiter.md
# mips_axi_rd_arbiter

Read-channel arbiter placed between the MIPS core's two read requesters (instruction fetch, data load) and the single AXI AR/R channel pair of the CPU top level. It serialises both request streams onto one AXI read port with at most one outstanding transaction. It registers AR outputs and routes the R response back to the requester that owns the transaction. It also maintains grant, wait and error counters for the performance-counter bank.

## Interface
Parameters:
- ADDR_W, 32, address width of requests and araddr
- DATA_W, 32, read data width

Ports:
- mips_cpu_clk  in  1  single clock, all state on rising edge
- mips_cpu_reset_n  in  1  reset, asynchronous, active-low
- inst_req_valid  in  1  fetch request; held until inst_req_ack
- inst_req_addr  in  ADDR_W  fetch address; stable while valid
- inst_req_ack  out  1  one-cycle pulse when the fetch AR handshake completes
- inst_rdata  out  DATA_W  fetch data; zero when not owner
- inst_rvalid  out  1  fetch data valid
- inst_rack  in  1  fetch requester accepts data
- data_req_valid, data_req_addr, data_req_ack, data_rdata, data_rvalid, data_rack: same as inst_* for the load requester
- axi_araddr  out  ADDR_W  registered AR address
- axi_arvalid  out  1  registered AR valid
- axi_arready  in  1  slave AR ready
- axi_rdata  in  DATA_W  slave read data
- axi_rresp  in  2  slave response; nonzero means error
- axi_rvalid  in  1  slave R valid
- axi_rready  out  1  R ready
- cnt_inst_grant, cnt_data_grant, cnt_wait, cnt_rd_err  out  32 each  counters

## Operation
- FSM states: IDLE, ADDR, DATA. One owner register `own` (0 = inst, 1 = data) and `last_grant`.
- IDLE: if either valid is high, pick a winner, latch its address into axi_araddr, set `own`, set axi_arvalid=1 and go to ADDR. If neither is high, stay in IDLE.
- ADDR: axi_arvalid=1 and axi_araddr are held. When axi_arready=1: pulse the owner's *_req_ack in the same cycle (combinational on arready), clear axi_arvalid, increment the owner's grant counter, and go to DATA.
- DATA:
  - axi_rready = owner's *_rack.
  - Owner's *_rvalid = axi_rvalid and owner's *_rdata = axi_rdata. Non-owner rvalid=0, rdata=0.
  - On axi_rvalid & axi_rready: if axi_rresp != 0, increment cnt_rd_err. Data is still delivered. Go to IDLE.
- Outside DATA, axi_rready=0 and both *_rvalid=0.
- Default arbitration is fixed priority: data beats inst when both are valid in IDLE.
- A request that drops its valid after the grant does not cancel the transaction. The AXI transaction completes and still requires the owner's rack.
- cnt_wait increments in every cycle that is (ADDR & ~axi_arready) or (DATA & ~axi_rvalid).
- All counters are 32-bit and wrap 0xFFFFFFFF -> 0 with no saturation.

## Timing
- Reset values: state=IDLE, axi_arvalid=0, axi_araddr=0, axi_rready=0, both acks=0, both rvalid=0, both rdata=0, all counters=0, last_grant=data, own=inst.
- Reset assertion acts immediately (async) and may occur mid-transaction. Any in-flight AXI response is dropped; the slave is reset by the same reset.
- Latency, with arready and rvalid tied high and rack high:
  - Request seen in IDLE at cycle N.
  - arvalid rises at N+1; ack pulses at N+1.
  - DATA at N+2; data handshake at N+2.
  - IDLE at N+3.
  - One transaction per 3 cycles best case.
- New arbitration happens only in IDLE, never in ADDR or DATA. A request arriving during an outstanding transaction waits.
- axi_araddr and axi_arvalid are glitch-free register outputs. *_req_ack, axi_rready and *_rvalid are combinational.
- Simultaneous valid in IDLE is resolved by the arbitration rule, in the same cycle.

## Configuration
- MIPS_RD_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, the requester not equal to last_grant wins.
  - last_grant updates at each ADDR->DATA transition.
  - Because last_grant resets to data, the first tie goes to inst.
  - A lone requester always wins.
- MIPS_RD_ARB_RR_EN undefined: fixed data-over-inst priority. last_grant is unused and may be removed.

## Test plan
- Single fetch: inst_req_valid=1, addr=0x0000_0100, arready=1, rdata=0x2402_0005 with rvalid=1, inst_rack=1 -> arvalid at N+1 with araddr=0x100, inst_req_ack pulse at N+1, inst_rvalid=1 and inst_rdata=0x2402_0005 at N+2, cnt_inst_grant=1.
- Tie, no macro: both valid, data addr 0x2000, inst addr 0x0104 -> data granted first, inst second; cnt_data_grant=1, cnt_inst_grant=1. Back-to-back ties always favour data.
- Tie, MIPS_RD_ARB_RR_EN: four consecutive ties -> grant order inst, data, inst, data.
- Backpressure: arready low 3 cycles, then rvalid low 2 cycles -> araddr/arvalid stable throughout, no ack until arready, cnt_wait=5, non-owner rvalid=0.
- Error response: rresp=2'b10 on a data read -> data_rvalid=1 with the returned data, cnt_rd_err=1, FSM back in IDLE.
- Async reset in DATA while rvalid is low -> arvalid, rready and all counters are 0 immediately without a clock edge; after release, a new fetch completes normally.
